seq_restoring_divider: RTL

- Sequential shift-subtract (restoring) divider: 2W-bit dividend ÷ W-bit divisor, giving a W-bit quotient and a W-bit remainder.
- Inverse companion of the team's 4x4 shift-add multiplier. It consumes an 8-bit product-style operand and recovers the factor and remainder.
- Uses the same START/READY control style as the multiplier: one START pulse launches, READY high means idle and result valid.
- Sits alongside the multiplier in the arithmetic benchmark set.

---
 rtl/seq_div_pkg.sv | 22 ++
 rtl/div_sub_step.sv | 19 +
 rtl/seq_restoring_divider.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

   // Default operand width: dividend is 2*DIV_W bits, divisor/quotient/remainder DIV_W bits.
   localparam int unsigned DIV_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bits needed to count 0..v-1; never less than one bit.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
module div_sub_step
   import seq_div_pkg::*;
#(
   parameter int unsigned W = DIV_W
) (
   input  logic [W:0]   t,
   input  logic [W-1:0] d,
   output logic [W:0]   pr_next,
   output logic         q_bit
);

   // Subtract when the divisor fits, otherwise restore (keep T unchanged).
   always_comb begin
      q_bit   = (t >= {1'b0, d});
      pr_next = q_bit ? (t - {1'b0, d}) : t;
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, W cycles per operation.
// START launches (or restarts) an operation; READY high means idle with a valid result.
module seq_restoring_divider
   import seq_div_pkg::*;
#(
   parameter int unsigned W = DIV_W
) (
   input  logic           CK,
   input  logic           RSTN,
   input  logic           START,
   input  logic [2*W-1:0] N,
   input  logic [W-1:0]   D,
   output logic [W-1:0]   Q,
   output logic [W-1:0]   R,
   output logic           READY,
   output logic           OVF,
   output logic           DIVZ
);

   localparam int unsigned   CNT_W    = clog2(W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [W:0]       pr_q,     pr_d;
   logic [W-1:0]     qs_q,     qs_d;
   logic [W-1:0]     d_q,      d_d;
   logic [W-1:0]     nlo_q,    nlo_d;
   logic             ovf_n_q,  ovf_n_d;
   logic             divz_n_q, divz_n_d;
   logic [W-1:0]     q_q,      q_d;
   logic [W-1:0]     r_q,      r_d;
   logic             ovf_q,    ovf_d;
   logic             divz_q,   divz_d;

   logic [W:0]       step_t;
   logic [W:0]       step_pr;
   logic             step_qbit;
   logic [W-1:0]     step_qs;
   logic             pr_msb_unused;

   // The top PR bit is shifted out before every trial subtract, so it never feeds back.
   assign pr_msb_unused = pr_q[W];

   assign step_t  = {pr_q[W-1:0], qs_q[W-1]};
   assign step_qs = {qs_q[W-2:0], step_qbit};

   div_sub_step #(.W(W)) u_step (
      .t       (step_t),
      .d       (d_q),
      .pr_next (step_pr),
      .q_bit   (step_qbit)
   );

   // Next-state logic: load on START (any state), iterate in RUN, publish on the last step.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pr_d     = pr_q;
      qs_d     = qs_q;
      d_d      = d_q;
      nlo_d    = nlo_q;
      ovf_n_d  = ovf_n_q;
      divz_n_d = divz_n_q;
      q_d      = q_q;
      r_d      = r_q;
      ovf_d    = ovf_q;
      divz_d   = divz_q;

      if (START) begin
         state_d  = RUN;
         d_d      = D;
         pr_d     = {1'b0, N[2*W-1:W]};
         qs_d     = N[W-1:0];
         nlo_d    = N[W-1:0];
         divz_n_d = (D == '0);
         ovf_n_d  = (D != '0) && (N[2*W-1:W] >= D);
         cnt_d    = '0;
      end else if (state_q == RUN) begin
         pr_d  = step_pr;
         qs_d  = step_qs;
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            // Divide-by-zero wins over overflow; both report all-ones and the latched low half.
            if (divz_n_q) begin
               q_d    = '1;
               r_d    = nlo_q;
               ovf_d  = 1'b0;
               divz_d = 1'b1;
            end else if (ovf_n_q) begin
               q_d    = '1;
               r_d    = nlo_q;
               ovf_d  = 1'b1;
               divz_d = 1'b0;
            end else begin
               q_d    = step_qs;
               r_d    = step_pr[W-1:0];
               ovf_d  = 1'b0;
               divz_d = 1'b0;
            end
         end
      end
   end

   // State registers with synchronous active-low reset that overrides START.
   always_ff @(posedge CK) begin
      if (!RSTN) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pr_q     <= '0;
         qs_q     <= '0;
         d_q      <= '0;
         nlo_q    <= '0;
         ovf_n_q  <= 1'b0;
         divz_n_q <= 1'b0;
         q_q      <= '0;
         r_q      <= '0;
         ovf_q    <= 1'b0;
         divz_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pr_q     <= pr_d;
         qs_q     <= qs_d;
         d_q      <= d_d;
         nlo_q    <= nlo_d;
         ovf_n_q  <= ovf_n_d;
         divz_n_q <= divz_n_d;
         q_q      <= q_d;
         r_q      <= r_d;
         ovf_q    <= ovf_d;
         divz_q   <= divz_d;
      end
   end

   assign Q     = q_q;
   assign R     = r_q;
   assign OVF   = ovf_q;
   assign DIVZ  = divz_q;
   assign READY = (state_q == IDLE);

endmodule
